// File: rtl/tcm_dp.sv
// tcm_dp: dual-port, byte-writable tightly coupled memory with registered reads
// and a built-in byte-stream boot loader.
//   Port "if" : instruction fetch, read-only.
//   Port "d"  : load/store, byte-enabled writes, out-of-range error flag.
// Optional feature macro: TCM_BYPASS_EN
//   defined   -> a fetch of the index being written this cycle sees the merged post-write word
//   undefined -> read-first fetch (maps directly onto a true dual-port block RAM)
module tcm_dp #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter              INIT_FILE  = ""
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic                          if_req_i,
    input  logic [31:0]                   if_addr_i,
    output logic                          if_gnt_o,
    output logic                          if_valid_o,
    output logic [DATA_WIDTH-1:0]         if_data_o,

    input  logic                          d_req_i,
    input  logic                          d_we_i,
    input  logic [31:0]                   d_addr_i,
    input  logic [DATA_WIDTH-1:0]         d_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]       d_be_i,
    output logic                          d_gnt_o,
    output logic                          d_valid_o,
    output logic [DATA_WIDTH-1:0]         d_rdata_o,
    output logic                          d_err_o,

    input  logic                          ld_start_i,
    input  logic [$clog2(DEPTH):0]        ld_len_i,
    input  logic                          ld_valid_i,
    input  logic [7:0]                    ld_byte_i,
    output logic                          ld_ready_o,
    output logic                          ld_busy_o,
    output logic                          ld_done_o
);

    localparam int unsigned NB   = DATA_WIDTH / 8;
    localparam int unsigned IDX  = $clog2(DEPTH);
    localparam int unsigned OFF  = $clog2(NB);
    localparam int unsigned ABIT = IDX + OFF;
    localparam int unsigned BCW  = (OFF > 0) ? OFF : 1;
    localparam int unsigned LW   = IDX + 1;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_LOAD  = 2'd1,
        LD_FLUSH = 2'd2
    } ld_state_e;

    // Storage array; contents survive reset by design.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Address decode
    logic [IDX-1:0] if_idx_c;
    logic [IDX-1:0] d_idx_c;
    logic           if_oor_c;
    logic           d_oor_c;
    logic           unused_c;

    assign if_idx_c = if_addr_i[ABIT-1:OFF];
    assign d_idx_c  = d_addr_i[ABIT-1:OFF];
    assign if_oor_c = |if_addr_i[31:ABIT];
    assign d_oor_c  = |d_addr_i[31:ABIT];
    // Byte-offset bits inside a word carry no meaning for word accesses.
    assign unused_c = ^{if_addr_i[OFF-1:0], d_addr_i[OFF-1:0]};

    // Grants: both ports are locked out while the loader owns the array.
    logic d_wr_c;

    assign if_gnt_o = if_req_i & ~ld_busy_o;
    assign d_gnt_o  = d_req_i & ~ld_busy_o;
    assign d_wr_c   = d_gnt_o & d_we_i & ~d_oor_c;

    // Loader state
    ld_state_e              ld_state;
    logic [IDX-1:0]         ld_last;
    logic [IDX-1:0]         ld_wcnt;
    logic [BCW-1:0]         ld_bcnt;
    logic [DATA_WIDTH-1:0]  ld_shift;
    logic [DATA_WIDTH-1:0]  ld_word_c;
    logic                   ld_wr_c;
    logic                   ld_last_byte_c;

    // Little-endian assembly: each new byte enters at the top and shifts older bytes down.
    assign ld_word_c      = (ld_shift >> 8) | (DATA_WIDTH'(ld_byte_i) << (DATA_WIDTH - 8));
    assign ld_last_byte_c = (ld_bcnt == BCW'(NB - 1));
    assign ld_wr_c        = ld_ready_o & ld_valid_i & ld_last_byte_c;

    // Array write port: loader word or byte-enabled store (never both, grants are blocked while loading).
    always_ff @(posedge clk) begin
        if (ld_wr_c) begin
            mem[ld_wcnt] <= ld_word_c;
        end else if (d_wr_c) begin
            for (int k = 0; k < NB; k++) begin
                if (d_be_i[k]) begin
                    mem[d_idx_c][8*k +: 8] <= d_wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Fetch word selection, optionally forwarding a same-cycle store to the same index.
    logic [DATA_WIDTH-1:0] if_word_c;

    always_comb begin
        if_word_c = mem[if_idx_c];
`ifdef TCM_BYPASS_EN
        if (d_wr_c && (d_idx_c == if_idx_c)) begin
            for (int k = 0; k < NB; k++) begin
                if (d_be_i[k]) begin
                    if_word_c[8*k +: 8] = d_wdata_i[8*k +: 8];
                end
            end
        end
`endif
    end

    // Fetch response register; data holds between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid_o <= 1'b0;
            if_data_o  <= '0;
        end else begin
            if_valid_o <= if_gnt_o;
            if (if_gnt_o) begin
                if_data_o <= if_oor_c ? '0 : if_word_c;
            end
        end
    end

    // Data response register; writes report status only, read data holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_valid_o <= 1'b0;
            d_err_o   <= 1'b0;
            d_rdata_o <= '0;
        end else begin
            d_valid_o <= d_gnt_o;
            if (d_gnt_o) begin
                d_err_o <= d_oor_c;
                if (!d_we_i) begin
                    d_rdata_o <= d_oor_c ? '0 : mem[d_idx_c];
                end
            end
        end
    end

    // Boot loader FSM with registered ready/busy/done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_state   <= LD_IDLE;
            ld_last    <= '0;
            ld_wcnt    <= '0;
            ld_bcnt    <= '0;
            ld_shift   <= '0;
            ld_ready_o <= 1'b0;
            ld_busy_o  <= 1'b0;
            ld_done_o  <= 1'b0;
        end else begin
            ld_done_o <= 1'b0;
            case (ld_state)
                LD_IDLE: begin
                    if (ld_start_i) begin
                        ld_bcnt <= '0;
                        ld_wcnt <= '0;
                        if (ld_len_i == '0) begin
                            ld_done_o <= 1'b1;
                        end else begin
                            // Lengths beyond the array are clamped to a full fill.
                            if (ld_len_i > LW'(DEPTH)) begin
                                ld_last <= IDX'(DEPTH - 1);
                            end else begin
                                ld_last <= IDX'(ld_len_i - LW'(1));
                            end
                            ld_state   <= LD_LOAD;
                            ld_busy_o  <= 1'b1;
                            ld_ready_o <= 1'b1;
                        end
                    end
                end
                LD_LOAD: begin
                    if (ld_valid_i) begin
                        ld_shift <= ld_word_c;
                        if (ld_last_byte_c) begin
                            ld_bcnt <= '0;
                            if (ld_wcnt == ld_last) begin
                                ld_state   <= LD_FLUSH;
                                ld_ready_o <= 1'b0;
                                ld_done_o  <= 1'b1;
                            end else begin
                                ld_wcnt <= ld_wcnt + IDX'(1);
                            end
                        end else begin
                            ld_bcnt <= ld_bcnt + BCW'(1);
                        end
                    end
                end
                LD_FLUSH: begin
                    ld_state  <= LD_IDLE;
                    ld_busy_o <= 1'b0;
                end
                default: begin
                    ld_state   <= LD_IDLE;
                    ld_busy_o  <= 1'b0;
                    ld_ready_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tcm_dp.sv
// tb_tcm_dp: randomized scoreboard bench for tcm_dp (default parameters).
module tb_tcm_dp;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_valid_o;
    logic [31:0] if_data_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [3:0]  d_be_i;
    logic        d_gnt_o;
    logic        d_valid_o;
    logic [31:0] d_rdata_o;
    logic        d_err_o;
    logic        ld_start_i;
    logic [10:0] ld_len_i;
    logic        ld_valid_i;
    logic [7:0]  ld_byte_i;
    logic        ld_ready_o;
    logic        ld_busy_o;
    logic        ld_done_o;

    tcm_dp #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .INIT_FILE("")) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_valid_o(if_valid_o), .if_data_o(if_data_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_be_i(d_be_i), .d_gnt_o(d_gnt_o), .d_valid_o(d_valid_o), .d_rdata_o(d_rdata_o),
        .d_err_o(d_err_o),
        .ld_start_i(ld_start_i), .ld_len_i(ld_len_i), .ld_valid_i(ld_valid_i),
        .ld_byte_i(ld_byte_i), .ld_ready_o(ld_ready_o), .ld_busy_o(ld_busy_o),
        .ld_done_o(ld_done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference memory image
    logic [31:0] mem_m [DEPTH];

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
        logic        chk_data;
    } exp_t;

    exp_t if_q[$];
    exp_t d_q[$];
    exp_t ei;
    exp_t ed;
    logic exp_if_gnt = 1'b0;
    logic exp_d_gnt  = 1'b0;
    logic [31:0] last_if = 32'h0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic oor(input logic [31:0] a);
        return a[31:12] != 20'h0;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        if ($urandom_range(0, 15) == 0) begin
            a = $urandom | 32'h0000_1000;
        end else if ($urandom_range(0, 1) == 0) begin
            a = {20'h0, 10'($urandom_range(0, 15)), 2'($urandom)};
        end else begin
            a = {20'h0, 10'($urandom), 2'($urandom)};
        end
        return a;
    endfunction

    // Monitor: compare every DUT response against the head of its queue.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("if_gnt", if_gnt_o, exp_if_gnt);
            chk("d_gnt", d_gnt_o, exp_d_gnt);
            if (if_valid_o) begin
                if (if_q.size() == 0) begin
                    chk("if_unexpected_valid", 1, 0);
                end else begin
                    ei = if_q.pop_front();
                    chk("if_latency", cyc, ei.cyc);
                    chk("if_data", if_data_o, ei.data);
                    last_if = ei.data;
                end
            end else begin
                chk("if_hold", if_data_o, last_if);
            end
            if (d_valid_o) begin
                if (d_q.size() == 0) begin
                    chk("d_unexpected_valid", 1, 0);
                end else begin
                    ed = d_q.pop_front();
                    chk("d_latency", cyc, ed.cyc);
                    chk("d_err", d_err_o, ed.err);
                    if (ed.chk_data) chk("d_rdata", d_rdata_o, ed.data);
                end
            end
        end
    end

    task automatic drive_idle();
        if_req_i = 1'b0; if_addr_i = '0;
        d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_be_i = '0;
        ld_start_i = 1'b0; ld_len_i = '0; ld_valid_i = 1'b0; ld_byte_i = '0;
        exp_if_gnt = 1'b0; exp_d_gnt = 1'b0;
    endtask

    // One cycle of port traffic; expected responses come from the reference image.
    task automatic issue(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                         input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dbe);
        exp_t e;
        logic [31:0] fw;
        int fi;
        int di;
        @(posedge clk); #1;
        if_req_i = ir; if_addr_i = ia;
        d_req_i = dr; d_we_i = dwe; d_addr_i = da; d_wdata_i = dwd; d_be_i = dbe;
        exp_if_gnt = ir; exp_d_gnt = dr;
        fi = int'(ia[11:2]);
        di = int'(da[11:2]);
        if (ir) begin
            fw = oor(ia) ? 32'h0 : mem_m[fi];
`ifdef TCM_BYPASS_EN
            if (!oor(ia) && dr && dwe && !oor(da) && fi == di) begin
                for (int k = 0; k < 4; k++) if (dbe[k]) fw[8*k +: 8] = dwd[8*k +: 8];
            end
`endif
            e.cyc = cyc + 1; e.data = fw; e.err = 1'b0; e.chk_data = 1'b1;
            if_q.push_back(e);
        end
        if (dr) begin
            e.cyc = cyc + 1;
            e.err = oor(da);
            e.chk_data = !dwe;
            e.data = (dwe || oor(da)) ? 32'h0 : mem_m[di];
            if (dwe && !oor(da)) begin
                for (int k = 0; k < 4; k++) if (dbe[k]) mem_m[di][8*k +: 8] = dwd[8*k +: 8];
            end
            d_q.push_back(e);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_if_valid"}, if_valid_o, 0);
        chk({tag, "_if_data"}, if_data_o, 0);
        chk({tag, "_d_valid"}, d_valid_o, 0);
        chk({tag, "_d_rdata"}, d_rdata_o, 0);
        chk({tag, "_d_err"}, d_err_o, 0);
        chk({tag, "_ld_ready"}, ld_ready_o, 0);
        chk({tag, "_ld_busy"}, ld_busy_o, 0);
        chk({tag, "_ld_done"}, ld_done_o, 0);
    endtask

    // Assert reset immediately (caller positions it in the cycle), check outputs, release.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        drive_idle();
        #2;
        chk_reset_outputs(tag);
        if_q.delete();
        d_q.delete();
        last_if = 32'h0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Boot load of len words from a byte stream, with random gaps and blocked port traffic.
    task automatic load(input int len, input logic [7:0] bytes[$], input int gap_pct);
        int nw;
        int i;
        logic v;
        nw = (len > int'(DEPTH)) ? int'(DEPTH) : len;
        @(posedge clk); #1;
        drive_idle();
        ld_start_i = 1'b1;
        ld_len_i = 11'(len);
        @(posedge clk); #1;
        ld_start_i = 1'b0;
        if (nw == 0) begin
            @(negedge clk);
            chk("ld0_done", ld_done_o, 1);
            chk("ld0_busy", ld_busy_o, 0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("ld0_done_clear", ld_done_o, 0);
            return;
        end
        i = 0;
        while (i < nw * 4) begin
            v = ($urandom_range(0, 99) >= gap_pct);
            ld_valid_i = v;
            ld_byte_i = v ? bytes[i] : 8'($urandom);
            if_req_i = 1'($urandom); if_addr_i = rand_addr();
            d_req_i = 1'($urandom); d_we_i = 1'b0; d_addr_i = rand_addr();
            @(negedge clk);
            chk("ld_busy", ld_busy_o, 1);
            chk("ld_ready", ld_ready_o, 1);
            chk("ld_done_early", ld_done_o, 0);
            if (v) begin
                if (i % 4 == 3) begin
                    mem_m[i / 4] = {bytes[i], bytes[i-1], bytes[i-2], bytes[i-3]};
                end
                i++;
            end
            @(posedge clk); #1;
        end
        ld_valid_i = 1'b0;
        @(negedge clk);
        chk("ld_done", ld_done_o, 1);
        chk("ld_flush_busy", ld_busy_o, 1);
        chk("ld_flush_ready", ld_ready_o, 0);
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        chk("ld_done_once", ld_done_o, 0);
        chk("ld_busy_end", ld_busy_o, 0);
    endtask

    logic [7:0] bq[$];

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        drive_idle();
        rst_n = 1'b0;
        #3;
        chk_reset_outputs("por");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Fill the whole array; 1500 words is clamped to DEPTH.
        bq.delete();
        for (int i = 0; i < int'(DEPTH) * 4; i++) bq.push_back(8'($urandom));
        load(1500, bq, 30);

        // Short load with gaps: words 0x04030201 and 0x08070605.
        bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        load(2, bq, 50);
        issue(1, 32'h0, 1, 0, 32'h4, 32'h0, 4'h0);
        issue(1, 32'h4, 1, 0, 32'h0, 32'h0, 4'h0);

        // Zero-length load: done pulse only.
        bq.delete();
        load(0, bq, 0);

        // Byte-enable merge at 0x40.
        issue(0, 32'h0, 1, 1, 32'h0, 32'h0000_0013, 4'hF);
        issue(0, 32'h0, 1, 1, 32'h40, 32'h1122_3344, 4'hF);
        issue(0, 32'h0, 1, 1, 32'h40, 32'hAABB_CCDD, 4'b0101);
        issue(0, 32'h0, 1, 0, 32'h40, 32'h0, 4'h0);

        // Out-of-range read and write; word 0 shares index bits with 0x1000.
        issue(0, 32'h0, 1, 0, 32'h1000, 32'h0, 4'h0);
        issue(0, 32'h0, 1, 1, 32'h1000, 32'hFFFF_FFFF, 4'hF);
        issue(1, 32'h0, 1, 0, 32'h0, 32'h0, 4'h0);
        issue(1, 32'h1000, 0, 0, 32'h0, 32'h0, 4'h0);

        // Zero byte-enable write leaves the word intact.
        issue(0, 32'h0, 1, 1, 32'h44, 32'h5A5A_5A5A, 4'h0);
        issue(1, 32'h44, 0, 0, 32'h0, 32'h0, 4'h0);

        // Same-cycle fetch and write of 0x80.
        issue(0, 32'h0, 1, 1, 32'h80, 32'h0, 4'hF);
        issue(1, 32'h80, 1, 1, 32'h80, 32'hDEAD_BEEF, 4'hF);
        issue(1, 32'h80, 0, 0, 32'h0, 32'h0, 4'h0);

        // Reset while a fetch response is in flight; memory survives.
        issue(1, 32'h0, 1, 0, 32'h40, 32'h0, 4'h0);
        @(posedge clk); #1;
        do_reset("midrun");
        issue(1, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0);
        issue(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0);

        // Reset in mid-load: the one completed word stays, the rest is untouched.
        @(posedge clk); #1;
        ld_start_i = 1'b1; ld_len_i = 11'd4;
        @(posedge clk); #1;
        ld_start_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ld_valid_i = 1'b1;
            ld_byte_i = 8'(8'hA0 + i);
            @(posedge clk); #1;
        end
        mem_m[0] = 32'hA3A2_A1A0;
        do_reset("midload");
        issue(1, 32'h0, 1, 0, 32'h4, 32'h0, 4'h0);

        // Random traffic on both ports.
        for (int n = 0; n < 3000; n++) begin
            issue(1'($urandom_range(0, 3) != 0), rand_addr(),
                  1'($urandom_range(0, 3) != 0), 1'($urandom), rand_addr(),
                  $urandom, 4'($urandom));
        end
        issue(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("if_q_drained", if_q.size(), 0);
        chk("d_q_drained", d_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
